// File: rtl/case_demux_pkg.sv
// Shared types and constants for the case_demux slice.
// Holds the occupancy state encoding and the drop counter geometry.
// Combinational definitions only; no backpressure involvement.
package case_demux_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam int                    DROP_CNT_W   = 16;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = {DROP_CNT_W{1'b1}};

endpackage

// File: rtl/case_demux_dec.sv
// Select to one-hot decoder with an in-range flag.
// Purely combinational, zero latency.
// No backpressure; the outputs follow sel directly.
module case_demux_dec #(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  onehot,
  output logic             in_range
);

  // Everything defaults to zero so unselected bits can never float to X.
  always_comb begin
    onehot   = '0;
    in_range = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      case (sel)
        SEL_W'(i): begin
          onehot[i] = 1'b1;
          in_range  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/case_demux.sv
// Registered one-deep valid/ready demux; out-of-range handling set by CASE_DEMUX_DEFAULT_CH_EN.
// Latency: a beat accepted on edge k appears on out_valid after edge k.
// Backpressure: in_ready = EMPTY or the held channel's out_ready; full rate with no bubble.
module case_demux
  import case_demux_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int DATA_W     = 8,
  parameter int DEFAULT_CH = 0,
  parameter int SEL_W      = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic [DATA_W-1:0]     in_data,
  output logic [N_CH-1:0]       out_valid,
  input  logic [N_CH-1:0]       out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  output logic                  err,
  input  logic                  err_clr
);

  state_e              state, state_nxt;
  logic [SEL_W-1:0]    hold_ch, hold_ch_nxt;
  logic [DATA_W-1:0]   hold_data, hold_data_nxt;
  logic [N_CH-1:0]     in_oh, hold_oh;
  logic                in_range, hold_in_range;
  logic                drain, accept, load, drop;

  case_demux_dec #(.N_CH(N_CH), .SEL_W(SEL_W)) u_in_dec (
    .sel      (in_sel),
    .onehot   (in_oh),
    .in_range (in_range)
  );

  case_demux_dec #(.N_CH(N_CH), .SEL_W(SEL_W)) u_hold_dec (
    .sel      (hold_ch),
    .onehot   (hold_oh),
    .in_range (hold_in_range)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      hold_ch   <= '0;
      hold_data <= '0;
    end else begin
      state     <= state_nxt;
      hold_ch   <= hold_ch_nxt;
      hold_data <= hold_data_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    hold_ch_nxt   = hold_ch;
    hold_data_nxt = hold_data;
    load          = 1'b0;
    drop          = 1'b0;
    // Masking with the held one-hot makes other channels' readiness irrelevant.
    drain         = (state == FULL) && |(hold_oh & out_ready);
    in_ready      = (state == EMPTY) || drain;
    accept        = in_valid && in_ready;
`ifdef CASE_DEMUX_DEFAULT_CH_EN
    load          = accept;
    hold_ch_nxt   = (accept && !in_range) ? SEL_W'(DEFAULT_CH) : hold_ch_nxt;
`else
    load          = accept && in_range;
    drop          = accept && !in_range;
`endif
    if (load) begin
      state_nxt     = FULL;
      hold_data_nxt = in_data;
      if (in_range) hold_ch_nxt = in_sel;
    end else if (drain) begin
      state_nxt = EMPTY;
    end
  end

  assign out_valid = (state == FULL) ? hold_oh : '0;
  assign out_data  = hold_data;

`ifdef CASE_DEMUX_DEFAULT_CH_EN
  assign drop_cnt = '0;
  assign err      = 1'b0;

  logic unused_cfg;
  assign unused_cfg = &{1'b0, err_clr, drop};
`else
  // A drop in the same cycle as err_clr leaves a fresh count of one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      err      <= 1'b0;
    end else if (drop) begin
      err <= 1'b1;
      if (err_clr)                      drop_cnt <= DROP_CNT_W'(1);
      else if (drop_cnt != DROP_CNT_MAX) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end else if (err_clr) begin
      drop_cnt <= '0;
      err      <= 1'b0;
    end
  end
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, in_oh, hold_in_range, 32'(DEFAULT_CH)};

endmodule

// File: tb/tb_case_demux.sv
// Directed bench for case_demux: a 4-channel instance for routing/backpressure/reset,
// and a 3-channel instance (DEFAULT_CH=1) for out-of-range handling.
module tb_case_demux;

  logic        clk;
  logic        rst_n;

  logic        in_valid4, in_ready4, err_clr4, err4;
  logic [1:0]  in_sel4;
  logic [7:0]  in_data4, out_data4;
  logic [3:0]  out_valid4, out_ready4;
  logic [15:0] drop_cnt4;

  logic        in_valid3, in_ready3, err_clr3, err3;
  logic [1:0]  in_sel3;
  logic [7:0]  in_data3, out_data3;
  logic [2:0]  out_valid3, out_ready3;
  logic [15:0] drop_cnt3;

  int checks = 0;
  int errors = 0;

  case_demux #(.N_CH(4), .DATA_W(8), .DEFAULT_CH(0)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_sel(in_sel4), .in_data(in_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .drop_cnt(drop_cnt4), .err(err4), .err_clr(err_clr4)
  );

  case_demux #(.N_CH(3), .DATA_W(8), .DEFAULT_CH(1)) u3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_sel(in_sel3), .in_data(in_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .drop_cnt(drop_cnt3), .err(err3), .err_clr(err_clr3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid4 = 0; in_sel4 = 0; in_data4 = 0; out_ready4 = 0; err_clr4 = 0;
    in_valid3 = 0; in_sel3 = 0; in_data3 = 0; out_ready3 = 0; err_clr3 = 0;
    #12;
    checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL rst_in_ready_during got=%b exp=1", in_ready4); end
    #10 rst_n = 1'b1;
    step();
    checks++; if (out_valid4 !== 4'b0000) begin errors++; $display("FAIL rst_out_valid got=%b exp=0000", out_valid4); end
    checks++; if (out_data4 !== 8'h00) begin errors++; $display("FAIL rst_out_data got=%h exp=00", out_data4); end
    checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready4); end
    checks++; if (err4 !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err4); end
    checks++; if (drop_cnt4 !== 16'h0000) begin errors++; $display("FAIL rst_drop_cnt got=%h exp=0000", drop_cnt4); end
    checks++; if (out_valid3 !== 3'b000) begin errors++; $display("FAIL rst_out_valid3 got=%b exp=000", out_valid3); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_v [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [7:0] exp_d [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    out_ready4 = 4'b1111;
    in_valid4  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_sel4  = 2'(i);
      in_data4 = exp_d[i];
      checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", i, in_ready4); end
      step();
      checks++; if (out_valid4 !== exp_v[i]) begin errors++; $display("FAIL b2b_valid[%0d] got=%b exp=%b", i, out_valid4, exp_v[i]); end
      checks++; if (out_data4 !== exp_d[i]) begin errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, out_data4, exp_d[i]); end
    end
    in_valid4 = 1'b0;
    step();
    checks++; if (out_valid4 !== 4'b0000) begin errors++; $display("FAIL b2b_drained got=%b exp=0000", out_valid4); end
    checks++; if (out_data4 !== 8'hA3) begin errors++; $display("FAIL b2b_data_retained got=%h exp=a3", out_data4); end
  endtask

  task automatic test_backpressure();
    out_ready4 = 4'b0000;
    in_valid4 = 1'b1; in_sel4 = 2'd2; in_data4 = 8'h5A;
    step();
    in_sel4 = 2'd0; in_data4 = 8'h11;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid4 !== 4'b0100) begin errors++; $display("FAIL bp_valid[%0d] got=%b exp=0100", i, out_valid4); end
      checks++; if (out_data4 !== 8'h5A) begin errors++; $display("FAIL bp_data[%0d] got=%h exp=5a", i, out_data4); end
      checks++; if (in_ready4 !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready4); end
      step();
    end
    out_ready4 = 4'b0100;
    #1;
    checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL bp_drain_ready got=%b exp=1", in_ready4); end
    step();
    in_valid4 = 1'b0;
    checks++; if (out_valid4 !== 4'b0001) begin errors++; $display("FAIL bp_next_valid got=%b exp=0001", out_valid4); end
    checks++; if (out_data4 !== 8'h11) begin errors++; $display("FAIL bp_next_data got=%h exp=11", out_data4); end
    out_ready4 = 4'b0001;
    step();
    checks++; if (out_valid4 !== 4'b0000) begin errors++; $display("FAIL bp_final_empty got=%b exp=0000", out_valid4); end
  endtask

  task automatic test_ignored_ready();
    out_ready4 = 4'b1101;
    in_valid4 = 1'b1; in_sel4 = 2'd1; in_data4 = 8'h33;
    step();
    in_valid4 = 1'b0;
    step();
    checks++; if (out_valid4 !== 4'b0010) begin errors++; $display("FAIL ign_valid got=%b exp=0010", out_valid4); end
    checks++; if (out_data4 !== 8'h33) begin errors++; $display("FAIL ign_data got=%h exp=33", out_data4); end
    checks++; if (in_ready4 !== 1'b0) begin errors++; $display("FAIL ign_in_ready got=%b exp=0", in_ready4); end
    out_ready4 = 4'b0010;
    step();
    checks++; if (out_valid4 !== 4'b0000) begin errors++; $display("FAIL ign_drain got=%b exp=0000", out_valid4); end
  endtask

  task automatic test_out_of_range();
    out_ready3 = 3'b111;
    in_valid3 = 1'b1; in_sel3 = 2'd3; in_data3 = 8'h77;
    #1;
    checks++; if (in_ready3 !== 1'b1) begin errors++; $display("FAIL oor_in_ready got=%b exp=1", in_ready3); end
    step();
`ifdef CASE_DEMUX_DEFAULT_CH_EN
    in_valid3 = 1'b0; out_ready3 = 3'b000;
    checks++; if (out_valid3 !== 3'b010) begin errors++; $display("FAIL dflt_valid got=%b exp=010", out_valid3); end
    checks++; if (out_data3 !== 8'h77) begin errors++; $display("FAIL dflt_data got=%h exp=77", out_data3); end
    checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL dflt_err got=%b exp=0", err3); end
    checks++; if (drop_cnt3 !== 16'h0000) begin errors++; $display("FAIL dflt_drop got=%h exp=0000", drop_cnt3); end
    out_ready3 = 3'b010;
    step();
    checks++; if (out_valid3 !== 3'b000) begin errors++; $display("FAIL dflt_drain got=%b exp=000", out_valid3); end
`else
    checks++; if (out_valid3 !== 3'b000) begin errors++; $display("FAIL oor_valid1 got=%b exp=000", out_valid3); end
    checks++; if (drop_cnt3 !== 16'd1) begin errors++; $display("FAIL oor_drop1 got=%0d exp=1", drop_cnt3); end
    step();
    checks++; if (out_valid3 !== 3'b000) begin errors++; $display("FAIL oor_valid2 got=%b exp=000", out_valid3); end
    checks++; if (drop_cnt3 !== 16'd2) begin errors++; $display("FAIL oor_drop2 got=%0d exp=2", drop_cnt3); end
    checks++; if (err3 !== 1'b1) begin errors++; $display("FAIL oor_err got=%b exp=1", err3); end
    err_clr3 = 1'b1;
    step();
    checks++; if (err3 !== 1'b1) begin errors++; $display("FAIL oor_clr_set_err got=%b exp=1", err3); end
    checks++; if (drop_cnt3 !== 16'd1) begin errors++; $display("FAIL oor_clr_set_drop got=%0d exp=1", drop_cnt3); end
    in_valid3 = 1'b0;
    step();
    err_clr3 = 1'b0;
    checks++; if (err3 !== 1'b0) begin errors++; $display("FAIL oor_clr_err got=%b exp=0", err3); end
    checks++; if (drop_cnt3 !== 16'd0) begin errors++; $display("FAIL oor_clr_drop got=%0d exp=0", drop_cnt3); end
    in_valid3 = 1'b1; in_sel3 = 2'd2; in_data3 = 8'h44; out_ready3 = 3'b000;
    step();
    in_valid3 = 1'b0;
    checks++; if (out_valid3 !== 3'b100) begin errors++; $display("FAIL n3_inrange_valid got=%b exp=100", out_valid3); end
    checks++; if (out_data3 !== 8'h44) begin errors++; $display("FAIL n3_inrange_data got=%h exp=44", out_data3); end
    checks++; if (drop_cnt3 !== 16'd0) begin errors++; $display("FAIL n3_inrange_drop got=%0d exp=0", drop_cnt3); end
    out_ready3 = 3'b100;
    step();
`endif
  endtask

  task automatic test_async_reset();
    out_ready4 = 4'b0000;
    in_valid4 = 1'b1; in_sel4 = 2'd2; in_data4 = 8'hC3;
    step();
    in_valid4 = 1'b0;
    checks++; if (out_valid4 !== 4'b0100) begin errors++; $display("FAIL ar_loaded got=%b exp=0100", out_valid4); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid4 !== 4'b0000) begin errors++; $display("FAIL ar_valid got=%b exp=0000", out_valid4); end
    checks++; if (out_data4 !== 8'h00) begin errors++; $display("FAIL ar_data got=%h exp=00", out_data4); end
    checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL ar_in_ready got=%b exp=1", in_ready4); end
    #2 rst_n = 1'b1;
    step();
    checks++; if (out_valid4 !== 4'b0000) begin errors++; $display("FAIL ar_after got=%b exp=0000", out_valid4); end
    checks++; if (drop_cnt4 !== 16'd0) begin errors++; $display("FAIL ar_drop got=%0d exp=0", drop_cnt4); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_ignored_ready();
    test_out_of_range();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
